// File: rtl/alu_ejecucion.sv
// EX-stage ALU: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle shifter,
// valid/ready on both sides and registered result/zero/overflow flags.
module alu_ejecucion #(
  parameter int unsigned ANCHO    = 32,
  parameter int unsigned ANCHO_SH = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          aluctl_i,
  input  logic [ANCHO-1:0]    op_a_i,
  input  logic [ANCHO-1:0]    op_b_i,
  input  logic [ANCHO_SH-1:0] shamt_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ANCHO-1:0]    resultado_o,
  output logic                cero_o,
  output logic                desbordamiento_o
);

  localparam logic [3:0] CtlAnd  = 4'b0000;
  localparam logic [3:0] CtlOr   = 4'b0001;
  localparam logic [3:0] CtlAdd  = 4'b0010;
  localparam logic [3:0] CtlNor  = 4'b0011;
  localparam logic [3:0] CtlSll  = 4'b0100;
  localparam logic [3:0] CtlSrl  = 4'b0101;
  localparam logic [3:0] CtlSub  = 4'b0110;
  localparam logic [3:0] CtlSlt  = 4'b0111;
  localparam logic [3:0] CtlXor  = 4'b1000;
  localparam logic [3:0] CtlSrl2 = 4'b1001;
  localparam logic [3:0] CtlSra  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  typedef enum logic [1:0] {DirLeft, DirRightLog, DirRightArith} dir_e;

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d;
  logic [ANCHO-1:0]     sh_q, sh_d;
  logic [ANCHO_SH-1:0]  cnt_q, cnt_d;
  logic [ANCHO-1:0]     res_q, res_d;
  logic                 cero_q, cero_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 is_shift;
  dir_e                 in_dir;
  logic [ANCHO-1:0]     suma, resta;
  logic                 menor;
  logic [ANCHO-1:0]     alu_res;
  logic                 alu_ovf;
  logic [ANCHO-1:0]     sh_next;
  logic                 load_res;

  assign in_ready_o       = (state_q == StIdle);
  assign out_valid_o      = (state_q == StDone);
  assign accept           = in_valid_i && in_ready_o;
  assign resultado_o      = res_q;
  assign cero_o           = cero_q;
  assign desbordamiento_o = ovf_q;

  assign suma  = op_a_i + op_b_i;
  assign resta = op_a_i - op_b_i;
  // Direct signed compare stays correct where the sign of a - b would overflow.
  assign menor = $signed(op_a_i) < $signed(op_b_i);

  // Decode of the requested operation for the single-cycle path.
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_shift = 1'b0;
    in_dir   = DirLeft;
    unique case (aluctl_i)
      CtlAnd: alu_res = op_a_i & op_b_i;
      CtlOr:  alu_res = op_a_i | op_b_i;
      CtlNor: alu_res = ~(op_a_i | op_b_i);
      CtlXor: alu_res = op_a_i ^ op_b_i;
      CtlAdd: begin
        alu_res = suma;
        alu_ovf = (op_a_i[ANCHO-1] == op_b_i[ANCHO-1]) && (suma[ANCHO-1] != op_a_i[ANCHO-1]);
      end
      CtlSub: begin
        alu_res = resta;
        alu_ovf = (op_a_i[ANCHO-1] != op_b_i[ANCHO-1]) && (resta[ANCHO-1] != op_a_i[ANCHO-1]);
      end
      CtlSlt: alu_res = {{(ANCHO-1){1'b0}}, menor};
      CtlSll: begin
        is_shift = 1'b1;
        in_dir   = DirLeft;
      end
      CtlSrl, CtlSrl2: begin
        is_shift = 1'b1;
        in_dir   = DirRightLog;
      end
      CtlSra: begin
        is_shift = 1'b1;
        in_dir   = DirRightArith;
      end
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    sh_next = sh_q;
    unique case (dir_q)
      DirLeft:       sh_next = {sh_q[ANCHO-2:0], 1'b0};
      DirRightLog:   sh_next = {1'b0, sh_q[ANCHO-1:1]};
      DirRightArith: sh_next = {sh_q[ANCHO-1], sh_q[ANCHO-1:1]};
      default:       sh_next = sh_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    cero_d   = cero_q;
    load_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift) begin
            dir_d = in_dir;
            sh_d  = op_b_i;
            cnt_d = shamt_i;
            if (shamt_i == '0) begin
              res_d    = op_b_i;
              ovf_d    = 1'b0;
              load_res = 1'b1;
              state_d  = StDone;
            end else begin
              state_d = StShift;
            end
          end else begin
            res_d    = alu_res;
            ovf_d    = alu_ovf;
            load_res = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - ANCHO_SH'(1);
        if (cnt_q == ANCHO_SH'(1)) begin
          res_d    = sh_next;
          ovf_d    = 1'b0;
          load_res = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_res) begin
      cero_d = (res_d == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dir_q   <= DirLeft;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cero_q  <= cero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_ejecucion.sv
// Self-checking bench for alu_ejecucion: directed vector table, hand-written
// reset/backpressure sequences and randomized ops against a behavioural model.
module tb_alu_ejecucion;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  aluctl_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  shamt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] resultado_o;
  logic        cero_o;
  logic        desbordamiento_o;

  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  alu_ejecucion #(.ANCHO(32), .ANCHO_SH(5)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .aluctl_i         (aluctl_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .shamt_i          (shamt_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .resultado_o      (resultado_o),
    .cero_o           (cero_o),
    .desbordamiento_o (desbordamiento_o)
  );

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [31:0] res, input logic ovf,
                              input int lat);
    vec_t v;
    v.ctl = ctl; v.a = a; v.b = b; v.sh = sh; v.res = res; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  // Behavioural reference from the operation definitions, using wide signed arithmetic.
  function automatic vec_t model(input logic [3:0] ctl, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    vec_t   v;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = mk(ctl, a, b, sh, 32'h0, 1'b0, 1);
    case (ctl)
      4'd0: v.res = a & b;
      4'd1: v.res = a | b;
      4'd3: v.res = ~(a | b);
      4'd8: v.res = a ^ b;
      4'd2: begin
        s = sa + sb;
        v.res = s[31:0];
        v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = sa - sb;
        v.res = s[31:0];
        v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: v.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: begin v.res = b << sh; v.lat = int'(sh) + 1; end
      4'd5, 4'd9: begin v.res = b >> sh; v.lat = int'(sh) + 1; end
      4'd10: begin v.res = $signed(b) >>> sh; v.lat = int'(sh) + 1; end
      default: v.res = 32'h0;
    endcase
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk_i);
    check({tag, " in_ready"}, {31'b0, in_ready_o}, 32'd1);
    aluctl_i = v.ctl; op_a_i = v.a; op_b_i = v.b; shamt_i = v.sh; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 60) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " resultado"}, resultado_o, v.res);
    check({tag, " cero"}, {31'b0, cero_o}, {31'b0, v.res == 32'h0});
    check({tag, " desbordamiento"}, {31'b0, desbordamiento_o}, {31'b0, v.ovf});
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    check({tag, " idle after handshake"}, {30'b0, in_ready_o, out_valid_o}, 32'd2);
  endtask

  initial begin
    int cyc;
    logic seen;
    vec_t r;
    in_valid_i = 1'b0; out_ready_i = 1'b0; aluctl_i = 4'h0;
    op_a_i = '0; op_b_i = '0; shamt_i = '0;
    rst_ni = 1'b0;
    #12;
    check("reset resultado", resultado_o, 32'h0);
    check("reset flags/valid", {29'b0, cero_o, desbordamiento_o, out_valid_o}, 32'h0);
    rst_ni = 1'b1;
    #1;
    check("in_ready after reset", {31'b0, in_ready_o}, 32'd1);

    vecs.push_back(mk(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 1));
    vecs.push_back(mk(4'b0110, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1));
    vecs.push_back(mk(4'b0111, 32'h80000000, 32'h1, 5'd0, 32'h1, 1'b0, 1));
    vecs.push_back(mk(4'b0111, 32'h1, 32'h80000000, 5'd0, 32'h0, 1'b0, 1));
    vecs.push_back(mk(4'b1010, 32'h0, 32'hF0000000, 5'd4, 32'hFF000000, 1'b0, 5));
    vecs.push_back(mk(4'b0101, 32'h0, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 5));
    vecs.push_back(mk(4'b1001, 32'h0, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 5));
    vecs.push_back(mk(4'b0100, 32'h0, 32'h00001234, 5'd0, 32'h00001234, 1'b0, 1));
    vecs.push_back(mk(4'b0100, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 32));
    vecs.push_back(mk(4'b1100, 32'hDEADBEEF, 32'h12345678, 5'd7, 32'h0, 1'b0, 1));
    vecs.push_back(mk(4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h0F000F00, 1'b0, 1));
    vecs.push_back(mk(4'b0001, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, 1));
    vecs.push_back(mk(4'b0011, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h000F000F, 1'b0, 1));
    vecs.push_back(mk(4'b0110, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 1));
    vecs.push_back(mk(4'b1010, 32'h0, 32'h40000000, 5'd3, 32'h08000000, 1'b0, 4));

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and new requests be ignored while DONE stalls.
    @(negedge clk_i);
    aluctl_i = 4'b1000; op_a_i = 32'hFFFF0000; op_b_i = 32'h0F0F0F0F; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    aluctl_i = 4'b0010; op_a_i = 32'h11111111; op_b_i = 32'h22222222;
    for (int i = 0; i < 10; i++) begin
      check("bp resultado", resultado_o, 32'hF0F00F0F);
      check("bp ready/valid", {30'b0, in_ready_o, out_valid_o}, 32'd1);
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("bp release ready/valid", {30'b0, in_ready_o, out_valid_o}, 32'd2);
    check("bp release resultado", resultado_o, 32'hF0F00F0F);
    @(negedge clk_i);
    in_valid_i = 1'b0; out_ready_i = 1'b0;

    // Reset in the middle of a long shift.
    run_op(mk(4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1), "pre-reset add");
    @(negedge clk_i);
    aluctl_i = 4'b0100; op_a_i = 32'h0; op_b_i = 32'h1; shamt_i = 5'd31; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid-shift reset resultado", resultado_o, 32'h0);
    check("mid-shift reset flags/valid",
          {29'b0, cero_o, desbordamiento_o, out_valid_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("in_ready after mid-shift reset", {31'b0, in_ready_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o) seen = 1'b1;
    end
    check("no stale result after reset", {31'b0, seen}, 32'd0);

    // Randomized operations against the model; shift amounts drawn over the full range.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      logic [4:0]  s;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = {b[31], a[30:0]};
        1: b = a;
        default: ;
      endcase
      s = 5'($urandom_range(0, 31));
      r = model(c, a, b, s);
      run_op(r, $sformatf("rand%0d ctl=%0h a=%08h b=%08h sh=%0d", i, c, a, b, s));
    end

    cyc = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_ejecucion.md
Name: alu_ejecucion

Overview:
- EX-stage ALU that consumes the 4-bit ALUctl code produced by the ALU control decoder.
- Executes the selected operation on two 32-bit operands and returns a registered result, zero flag and overflow flag.
- Shifts are done by an area-saving iterative shifter (one bit per cycle), so the block uses a valid/ready handshake on both its input side and its output side.

Parameters:
- ANCHO, 32, datapath width in bits. Shift amounts wider than this are not supported.
- ANCHO_SH, 5, shift-amount width; must equal log2(ANCHO).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request is valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- ALUctl  input  4  operation code from the ALU control decoder.
- op_a  input  ANCHO  operand A (rs).
- op_b  input  ANCHO  operand B (rt or immediate); this is the value shifted.
- shamt  input  ANCHO_SH  shift amount, already selected upstream (instruction shamt field or rs[4:0]).
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- resultado  output  ANCHO  registered result.
- cero  output  1  registered; 1 when resultado == 0.
- desbordamiento  output  1  registered; signed overflow, meaningful for ADD/SUB only.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; resultado = 0, cero = 0, desbordamiento = 0, out_valid = 0.
  - in_ready = 1 once rst_n is high and the state is IDLE.
  - A reset during SHIFT or DONE aborts the operation; no result is ever presented.
- FSM states are IDLE, SHIFT and DONE:
  - in_ready = (state == IDLE); out_valid = (state == DONE).
- Accept rule: in_valid && in_ready at a rising edge latches ALUctl, op_a, op_b and shamt. Inputs are ignored outside IDLE.
- Non-shift codes (result computed at the accept edge, state goes to DONE, latency 1 edge):
  - 0000 AND; 0001 OR; 0011 NOR; 1000 XOR.
  - 0010 ADD, modulo 2^ANCHO.
  - 0110 SUB (a - b), modulo 2^ANCHO.
  - 0111 SLT: resultado = 1 if signed(op_a) < signed(op_b), else 0. Must be correct even when a - b overflows.
  - Any other code (1011–1111): resultado = 0.
- Shift codes:
  - 0100 SLL (logical left).
  - 0101 SRL and 1001 SRL (logical right; both codes behave identically).
  - 1010 SRA (arithmetic right, replicates op_b[ANCHO-1]).
- Shift sequencing:
  - At accept, the shift register loads op_b and a counter loads shamt.
  - shamt == 0: go to DONE with resultado = op_b.
  - Otherwise go to SHIFT, shift one bit per cycle and decrement the counter; when the counter reaches 0, go to DONE.
  - Latency from the accept edge to out_valid high = shamt + 1 edges.
- Flags:
  - desbordamiento is set only for ADD (operands of the same sign, result sign differs) and SUB (operands of different signs, result sign differs from op_a). It is 0 for all other codes.
  - cero is computed from the final result, so it is only meaningful in DONE.
- DONE:
  - resultado and both flags stay stable while out_valid && !out_ready.
  - When out_ready is high at an edge, the state goes to IDLE. No new request is accepted in that same cycle.
  - Throughput: one operation per (latency + 1) cycles at minimum.
- resultado holds its last value while in IDLE and SHIFT; it updates only on entry to DONE.

Test Plan:
- Reset mid-shift: accept SLL with op_b=1, shamt=31; assert rst_n low on the 5th cycle. -> Outputs are immediately 0 and out_valid=0; after release in_ready=1 and no stale result appears.
- ADD and SUB overflow: ADD 0x7FFFFFFF + 1 -> resultado 0x80000000, desbordamiento 1, out_valid one edge after accept. SUB 5 - 5 -> resultado 0, cero 1, desbordamiento 0.
- SLT with overflow operands: op_a=0x80000000, op_b=1 -> resultado 1. Then op_a=1, op_b=0x80000000 -> resultado 0. desbordamiento 0 in both cases.
- Shift latency and edge amounts:
  - SRA op_b=0xF0000000, shamt=4 -> resultado 0xFF000000, out_valid 5 edges after accept.
  - SRL same op_b, shamt=4 -> 0x0F000000.
  - shamt=0 -> resultado = op_b after 1 edge.
  - SLL op_b=1, shamt=31 -> 0x80000000 after 32 edges.
- Backpressure: hold out_ready=0 for 10 cycles after XOR 0xFFFF0000 ^ 0x0F0F0F0F. -> resultado stays 0xF0F00F0F and in_ready stays 0 throughout; raising in_valid with new operands has no effect; with out_ready=1 the state returns to IDLE next edge.
- Unused code 1100 with arbitrary operands -> resultado 0, cero 1, desbordamiento 0, latency 1 edge.
